// File: rtl/mips_pkg.sv
// Shared encodings, ALU ops, datapath selector enums and the decoded control word
// for the single-cycle mips core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03,
                         F_JR   = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_NOR = 6'h27,
                         F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP, PC_JR} pc_src_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_e;
  typedef enum logic [1:0] {WB_ALU, WB_DM, WB_PC4} wb_src_e;

  typedef struct packed {
    alu_op_e  alu_op;
    pc_src_e  pc_src;
    reg_dst_e reg_dst;
    wb_src_e  wb_src;
    logic     reg_we;
    logic     mem_we;
    logic     b_imm;
    logic     zext;
  } ctrl_t;

endpackage

// File: rtl/mips_if.sv
// Decode bus between the datapath (instruction fields, branch compare) and ctrl.
interface mips_if;
  import mips_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       eq;
  ctrl_t      ctl;

  modport master (input op, funct, eq, output ctl);
  modport slave  (output op, funct, eq, input ctl);
endinterface

// File: rtl/mips_alu.sv
// 32-bit ALU; carries and overflow are dropped, shifts act on b by shamt.
module alu
  import mips_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_LUI:  y = {b[15:0], 16'b0};
      ALU_SLL:  y = b << shamt;
      ALU_SRL:  y = b >> shamt;
      ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mips_ctrl.sv
// Instruction decoder. Extended instructions are decoded only when MIPS_EXT_INSN_EN
// is defined; otherwise those encodings fall through to the all-idle NOP word.
module ctrl
  import mips_pkg::*;
(
  mips_if.master bus
);

  ctrl_t c;

  always_comb begin
    c.alu_op  = ALU_ADD;
    c.pc_src  = PC_PLUS4;
    c.reg_dst = DST_RT;
    c.wb_src  = WB_ALU;
    c.reg_we  = 1'b0;
    c.mem_we  = 1'b0;
    c.b_imm   = 1'b0;
    c.zext    = 1'b0;
    case (bus.op)
      OP_RTYPE: begin
        c.reg_dst = DST_RD;
        case (bus.funct)
          F_ADDU: c.reg_we = 1'b1;
          F_SUBU: begin c.reg_we = 1'b1; c.alu_op = ALU_SUB; end
          F_AND:  begin c.reg_we = 1'b1; c.alu_op = ALU_AND; end
          F_OR:   begin c.reg_we = 1'b1; c.alu_op = ALU_OR;  end
          F_SLT:  begin c.reg_we = 1'b1; c.alu_op = ALU_SLT; end
          F_JR:   c.pc_src = PC_JR;
`ifdef MIPS_EXT_INSN_EN
          F_SLL:  begin c.reg_we = 1'b1; c.alu_op = ALU_SLL;  end
          F_SRL:  begin c.reg_we = 1'b1; c.alu_op = ALU_SRL;  end
          F_SRA:  begin c.reg_we = 1'b1; c.alu_op = ALU_SRA;  end
          F_SLTU: begin c.reg_we = 1'b1; c.alu_op = ALU_SLTU; end
          F_NOR:  begin c.reg_we = 1'b1; c.alu_op = ALU_NOR;  end
`endif
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin c.reg_we = 1'b1; c.b_imm = 1'b1; end
      OP_ORI: begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.zext = 1'b1; c.alu_op = ALU_OR; end
      OP_LUI: begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.alu_op = ALU_LUI; end
      OP_LW:  begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.wb_src = WB_DM; end
      OP_SW:  begin c.mem_we = 1'b1; c.b_imm = 1'b1; end
      OP_BEQ: if (bus.eq) c.pc_src = PC_BRANCH;
      OP_J:   c.pc_src = PC_JUMP;
      OP_JAL: begin
        c.pc_src = PC_JUMP; c.reg_we = 1'b1; c.reg_dst = DST_RA; c.wb_src = WB_PC4;
      end
`ifdef MIPS_EXT_INSN_EN
      OP_BNE:   if (!bus.eq) c.pc_src = PC_BRANCH;
      OP_SLTI:  begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.alu_op = ALU_SLT;  end
      // sltiu sign-extends its immediate, then compares unsigned
      OP_SLTIU: begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.alu_op = ALU_SLTU; end
      OP_ANDI:  begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.zext = 1'b1; c.alu_op = ALU_AND; end
      OP_XORI:  begin c.reg_we = 1'b1; c.b_imm = 1'b1; c.zext = 1'b1; c.alu_op = ALU_XOR; end
`endif
      default: ;
    endcase
  end

  assign bus.ctl = c;

endmodule

// File: rtl/mips_stor.sv
// Storage leaves: instruction memory, register file, data memory. No reset on
// contents so that preloaded images survive rst.
module im_4k #(parameter int DEPTH = 1024) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              dout
);
  logic [31:0] im [0:DEPTH-1];

  // write port is a loader hook; the core ties it off
  always_ff @(posedge clk) if (we) im[addr] <= wdata;
  assign dout = im[addr];
endmodule

module gpr (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] gpr [0:31];

  always_ff @(posedge clk) if (we && wa != 5'd0) gpr[wa] <= wd;
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : gpr[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : gpr[ra2];
endmodule

module dm_4k #(parameter int DEPTH = 1024) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              din,
  output logic [31:0]              dout
);
  logic [31:0] dm [0:DEPTH-1];

  always_ff @(posedge clk) if (we) dm[addr] <= din;
  assign dout = dm[addr];
endmodule

// File: rtl/mips.sv
// Single-cycle MIPS-I subset core. Define MIPS_EXT_INSN_EN to add the extended
// shift/compare/logic instructions and bne.
module mips
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_DEPTH = 1024,
  parameter int          DM_DEPTH = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);

  logic [31:0] pc, npc, pc4, instr;
  logic [31:0] rd1, rd2, imm, imm_sx, alu_b, alu_y, dm_q, wd;
  logic [4:0]  wa;

  mips_if bus ();

  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= PC_RESET;
    else     pc <= npc;

  im_4k #(.DEPTH(IM_DEPTH)) U_im_4k (
    .clk(clk), .we(1'b0), .addr(pc[IAW+1:2]), .wdata(32'd0), .dout(instr)
  );

  assign bus.op    = instr[31:26];
  assign bus.funct = instr[5:0];
  assign bus.eq    = (rd1 == rd2);

  ctrl U_ctrl (.bus(bus.master));

  assign imm_sx = {{16{instr[15]}}, instr[15:0]};
  assign imm    = bus.ctl.zext ? {16'd0, instr[15:0]} : imm_sx;
  assign alu_b  = bus.ctl.b_imm ? imm : rd2;
  assign pc4    = pc + 32'd4;

  always_comb begin
    npc = pc4;
    case (bus.ctl.pc_src)
      PC_BRANCH: npc = pc4 + {imm_sx[29:0], 2'b00};
      PC_JUMP:   npc = {pc4[31:28], instr[25:0], 2'b00};
      PC_JR:     npc = rd1;
      default:   npc = pc4;
    endcase
  end

  always_comb begin
    wa = instr[20:16];
    case (bus.ctl.reg_dst)
      DST_RD:  wa = instr[15:11];
      DST_RA:  wa = 5'd31;
      default: wa = instr[20:16];
    endcase
  end

  always_comb begin
    wd = alu_y;
    case (bus.ctl.wb_src)
      WB_DM:   wd = dm_q;
      WB_PC4:  wd = pc4;
      default: wd = alu_y;
    endcase
  end

  // writes landing on an edge while rst is high are dropped
  gpr U_gpr (
    .clk(clk), .we(bus.ctl.reg_we & ~rst),
    .ra1(instr[25:21]), .ra2(instr[20:16]), .wa(wa), .wd(wd),
    .rd1(rd1), .rd2(rd2)
  );

  alu U_alu (
    .op(bus.ctl.alu_op), .a(rd1), .b(alu_b), .shamt(instr[10:6]), .y(alu_y)
  );

  dm_4k #(.DEPTH(DM_DEPTH)) U_dm_4k (
    .clk(clk), .we(bus.ctl.mem_we & ~rst), .addr(alu_y[DAW+1:2]),
    .din(rd2), .dout(dm_q)
  );

endmodule

// File: tb/tb_mips.sv
// Directed bench for mips: reset sequence, decoder spot checks, then a table of
// short programs each checked against a hand-computed register/memory/PC value.
module tb_mips;
  import mips_pkg::*;

  localparam int K_REG = 0, K_DM = 1, K_PC = 2;

  typedef struct {
    string       name;
    logic [31:0] p0, p1, p2, p3;
    int          ra; logic [31:0] va;
    int          rb; logic [31:0] vb;
    int          di; logic [31:0] dv;
    int          ncyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[$];
  logic [31:0] got;

  mips dut (.clk(clk), .rst(rst));

  mips_if tb_bus ();
  ctrl U_ref_ctrl (.bus(tb_bus.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [5:0] f, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, f};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jj(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] p0, p1, p2, p3,
                              input int ra, input logic [31:0] va,
                              input int rb, input logic [31:0] vb,
                              input int di, input logic [31:0] dv,
                              input int ncyc, input int kind, input int idx,
                              input logic [31:0] exp);
    vec_t v;
    v.name = name; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.ra = ra; v.va = va; v.rb = rb; v.vb = vb; v.di = di; v.dv = dv;
    v.ncyc = ncyc; v.kind = kind; v.idx = idx; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 32; k++) dut.U_gpr.gpr[k] = 32'd0;
    for (int k = 0; k < 16; k++) dut.U_dm_4k.dm[k] = 32'd0;
    for (int k = 0; k < 8; k++)  dut.U_im_4k.im[k] = 32'd0;
    dut.U_im_4k.im[0] = v.p0; dut.U_im_4k.im[1] = v.p1;
    dut.U_im_4k.im[2] = v.p2; dut.U_im_4k.im[3] = v.p3;
    if (v.ra > 0) dut.U_gpr.gpr[v.ra] = v.va;
    if (v.rb > 0) dut.U_gpr.gpr[v.rb] = v.vb;
    if (v.di >= 0) dut.U_dm_4k.dm[v.di] = v.dv;
    @(negedge clk);
    rst = 1'b0;
    repeat (v.ncyc) @(negedge clk);
    case (v.kind)
      K_DM:    got = dut.U_dm_4k.dm[v.idx];
      K_PC:    got = dut.pc;
      default: got = dut.U_gpr.gpr[v.idx];
    endcase
    check(v.name, got, v.exp);
  endtask

  initial begin
    logic [31:0] addu16, lw16, ori_ff, lui16, ori5678, jal_c03, sll_exp;
    addu16  = rr(6'h21, 5'd1, 5'd2, 5'd16, 5'd0);
    lw16    = ii(6'h23, 5'd0, 5'd16, 16'd16);
    ori_ff  = ii(6'h0D, 5'd16, 5'd16, 16'h00FF);
    lui16   = ii(6'h0F, 5'd0, 5'd16, 16'h1234);
    ori5678 = ii(6'h0D, 5'd16, 5'd16, 16'h5678);
    jal_c03 = jj(6'h03, 26'h0000C03);
`ifdef MIPS_EXT_INSN_EN
    sll_exp = 32'h0000_0010;
`else
    sll_exp = 32'h0000_AAAA;
`endif

    // Reset: preloaded register survives, pending write suppressed while rst high
    dut.U_gpr.gpr[16] = 32'hA5A5A5A5;
    dut.U_im_4k.im[0] = ii(6'h0D, 5'd0, 5'd16, 16'h0077);
    #12 check("rst_pc", dut.pc, 32'h0000_3000);
    #18 rst = 1'b0;
    #2  check("rst_keep_gpr", dut.U_gpr.gpr[16], 32'hA5A5A5A5);
    check("rst_pc_after", dut.pc, 32'h0000_3000);
    #8  check("first_insn", dut.U_gpr.gpr[16], 32'h0000_0077);
    check("first_pc", dut.pc, 32'h0000_3004);
    #3  rst = 1'b1;
    #1  check("async_rst_pc", dut.pc, 32'h0000_3000);

    // Decoder spot checks on a standalone ctrl instance
    tb_bus.funct = 6'h00; tb_bus.eq = 1'b0;
    tb_bus.op = 6'h23; #1;
    check("dec_lw_wb", 32'(tb_bus.ctl.wb_src), 32'(WB_DM));
    check("dec_lw_we", {30'd0, tb_bus.ctl.reg_we, tb_bus.ctl.mem_we}, 32'd2);
    tb_bus.op = 6'h2B; #1;
    check("dec_sw_we", {30'd0, tb_bus.ctl.reg_we, tb_bus.ctl.mem_we}, 32'd1);
    tb_bus.op = 6'h04; tb_bus.eq = 1'b1; #1;
    check("dec_beq_eq", 32'(tb_bus.ctl.pc_src), 32'(PC_BRANCH));
    tb_bus.eq = 1'b0; #1;
    check("dec_beq_ne", 32'(tb_bus.ctl.pc_src), 32'(PC_PLUS4));

    vecs.push_back(mk("addu", addu16, 0, 0, 0, 1, 5, 2, 7, -1, 0, 1, K_REG, 16, 32'h0000000C));
    vecs.push_back(mk("addu_pc", addu16, 0, 0, 0, 1, 5, 2, 7, -1, 0, 1, K_PC, 0, 32'h00003004));
    vecs.push_back(mk("subu_wrap", rr(6'h23, 5'd1, 5'd2, 5'd16, 5'd0), 0, 0, 0,
                      1, 5, 2, 7, -1, 0, 1, K_REG, 16, 32'hFFFFFFFE));
    vecs.push_back(mk("slt_signed", rr(6'h2A, 5'd1, 5'd2, 5'd16, 5'd0), 0, 0, 0,
                      1, 32'hFFFFFFFF, 2, 7, -1, 0, 1, K_REG, 16, 32'h1));
    vecs.push_back(mk("slt_false", rr(6'h2A, 5'd2, 5'd1, 5'd16, 5'd0), 0, 0, 0,
                      1, 5, 2, 7, -1, 0, 1, K_REG, 16, 32'h0));
    vecs.push_back(mk("and", rr(6'h24, 5'd1, 5'd2, 5'd16, 5'd0), 0, 0, 0,
                      1, 5, 2, 7, -1, 0, 1, K_REG, 16, 32'h5));
    vecs.push_back(mk("or", rr(6'h25, 5'd1, 5'd2, 5'd16, 5'd0), 0, 0, 0,
                      1, 5, 2, 2, -1, 0, 1, K_REG, 16, 32'h7));
    vecs.push_back(mk("addi_neg", ii(6'h08, 5'd0, 5'd16, 16'hFFFF), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_REG, 16, 32'hFFFFFFFF));
    vecs.push_back(mk("addiu_sext", ii(6'h09, 5'd1, 5'd16, 16'h8000), 0, 0, 0,
                      1, 5, -1, 0, -1, 0, 1, K_REG, 16, 32'hFFFF8005));
    vecs.push_back(mk("ori_zext", ii(6'h0D, 5'd0, 5'd16, 16'h8000), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_REG, 16, 32'h00008000));
    vecs.push_back(mk("lw_ori", lw16, ori_ff, 0, 0, -1, 0, -1, 0, 4, 32'hDEADBEEF,
                      2, K_REG, 16, 32'hDEADBEFF));
    vecs.push_back(mk("sw", lw16, ori_ff, ii(6'h2B, 5'd0, 5'd16, 16'd0), 0,
                      -1, 0, -1, 0, 4, 32'hDEADBEEF, 3, K_DM, 0, 32'hDEADBEFF));
    vecs.push_back(mk("lw_addr_wrap", ii(6'h23, 5'd0, 5'd16, 16'h1010), 0, 0, 0,
                      -1, 0, -1, 0, 4, 32'hDEADBEEF, 1, K_REG, 16, 32'hDEADBEEF));
    vecs.push_back(mk("lui_ori", lui16, ori5678, 0, 0, -1, 0, -1, 0, -1, 0,
                      2, K_REG, 16, 32'h12345678));
    vecs.push_back(mk("r0_discard", lui16, ori5678, rr(6'h21, 5'd16, 5'd16, 5'd0, 5'd0), 0,
                      -1, 0, -1, 0, -1, 0, 3, K_REG, 0, 32'h0));
    vecs.push_back(mk("beq_taken", ii(6'h04, 5'd0, 5'd0, 16'd2), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_PC, 0, 32'h0000300C));
    vecs.push_back(mk("beq_not", ii(6'h04, 5'd1, 5'd2, 16'd2), 0, 0, 0,
                      1, 5, 2, 7, -1, 0, 1, K_PC, 0, 32'h00003004));
    vecs.push_back(mk("j_pc", jj(6'h02, 26'h0000C03), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_PC, 0, 32'h0000300C));
    vecs.push_back(mk("jal_ra", jj(6'h03, 26'h0000C04), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_REG, 31, 32'h00003004));
    vecs.push_back(mk("jal_pc", jj(6'h03, 26'h0000C04), 0, 0, 0,
                      -1, 0, -1, 0, -1, 0, 1, K_PC, 0, 32'h00003010));
    vecs.push_back(mk("jr_pc", jal_c03, ii(6'h0D, 5'd0, 5'd16, 16'd1), 0,
                      rr(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), -1, 0, -1, 0, -1, 0,
                      2, K_PC, 0, 32'h00003004));
    vecs.push_back(mk("jr_return", jal_c03, ii(6'h0D, 5'd0, 5'd16, 16'd1), 0,
                      rr(6'h08, 5'd31, 5'd0, 5'd0, 5'd0), -1, 0, -1, 0, -1, 0,
                      3, K_REG, 16, 32'h1));
    vecs.push_back(mk("undef_nop", {6'h3F, 5'd0, 5'd16, 16'h0001}, 0, 0, 0,
                      16, 32'h1111, -1, 0, -1, 0, 1, K_REG, 16, 32'h1111));
    vecs.push_back(mk("undef_pc", {6'h3F, 5'd0, 5'd16, 16'h0001}, 0, 0, 0,
                      16, 32'h1111, -1, 0, -1, 0, 1, K_PC, 0, 32'h00003004));
    vecs.push_back(mk("sll_ext", rr(6'h00, 5'd0, 5'd1, 5'd16, 5'd4), 0, 0, 0,
                      1, 1, 16, 32'hAAAA, -1, 0, 1, K_REG, 16, sll_exp));

    foreach (vecs[n]) run_vec(vecs[n]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
